// File: rtl/enemy_pkg.sv
// enemy_pkg: shared coordinate width, sprite geometry and FSM encoding for the enemy bullet path.
package enemy_pkg;
  localparam int COORD_W = 12;
  localparam int ENEMY_W = 32;
  localparam int ENEMY_H = 32;
  localparam int BULLET_W = 4;
  localparam int BULLET_H = 8;
  localparam int PLAYER_W = 48;
  localparam int PLAYER_H = 32;
  localparam int BULLET_SPEED = 4;
  localparam int SCREEN_H = 600;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_FLY = 2'd2;
  localparam logic [1:0] S_HIT = 2'd3;
  typedef enum logic [1:0] {IDLE = S_IDLE, LAUNCH = S_LAUNCH, FLY = S_FLY, HIT = S_HIT} state_e;
  typedef logic [COORD_W-1:0] coord_t;
endpackage

// File: rtl/enemy_bullet_ctl_if.sv
// enemy_bullet_ctl_if: fire request, enemy/player positions in; bullet position, draw enable and hit pulse out.
interface enemy_bullet_ctl_if;
  import enemy_pkg::*;
  logic shot_req;
  logic frame_tick;
  logic enemy_alive;
  coord_t enemy_x;
  coord_t enemy_y;
  coord_t player_x;
  coord_t player_y;
  coord_t bullet_x;
  coord_t bullet_y;
  logic bullet_active;
  logic player_hit;
  logic busy;
  modport master (
    output shot_req, frame_tick, enemy_alive, enemy_x, enemy_y, player_x, player_y,
    input bullet_x, bullet_y, bullet_active, player_hit, busy
  );
  modport slave (
    input shot_req, frame_tick, enemy_alive, enemy_x, enemy_y, player_x, player_y,
    output bullet_x, bullet_y, bullet_active, player_hit, busy
  );
endinterface

// File: rtl/bullet_hit_check.sv
// bullet_hit_check: strict axis-aligned overlap of rectangle A (AW x AH) and rectangle B (BW x BH).
module bullet_hit_check #(
  parameter int W = 12,
  parameter int AW = 4,
  parameter int AH = 8,
  parameter int BW = 48,
  parameter int BH = 32
) (
  input  logic [W-1:0] ax,
  input  logic [W-1:0] ay,
  input  logic [W-1:0] bx,
  input  logic [W-1:0] by,
  output logic         hit
);
  logic [W:0] ax_e, ay_e, bx_e, by_e;
  assign ax_e = {1'b0, ax};
  assign ay_e = {1'b0, ay};
  assign bx_e = {1'b0, bx};
  assign by_e = {1'b0, by};
  // one extra bit keeps the far edges from wrapping near the coordinate limit
  assign hit = (ax_e < bx_e + (W+1)'(BW)) && (bx_e < ax_e + (W+1)'(AW)) &&
               (ay_e < by_e + (W+1)'(BH)) && (by_e < ay_e + (W+1)'(AH));
endmodule

// File: rtl/enemy_bullet_ctl.sv
// enemy_bullet_ctl: spawns, moves and retires one enemy bullet and pulses player_hit on collision.
// Define ENEMY_SHOT_LATCH_EN to queue one fire request that arrives while a bullet is in flight.
module enemy_bullet_ctl
  import enemy_pkg::*;
(
  input logic pclk,
  input logic rst,
  enemy_bullet_ctl_if.slave bif
);
  state_e state_q, state_d;
  coord_t bullet_x_q, bullet_x_d, bullet_y_q, bullet_y_d;
  logic active_q, active_d, hit_q, hit_d, busy_q, shot_q, req_q;
  logic fire, launch, overlap;
  logic [COORD_W:0] y_sum;
  // shot_req is registered before edge detection so launch lands two edges after the rise
  assign fire = shot_q & ~req_q;
  assign y_sum = {1'b0, bullet_y_q} + (COORD_W+1)'(BULLET_SPEED);
  bullet_hit_check #(.W(COORD_W), .AW(BULLET_W), .AH(BULLET_H), .BW(PLAYER_W), .BH(PLAYER_H)) u_hit (
    .ax(bullet_x_q), .ay(bullet_y_q), .bx(bif.player_x), .by(bif.player_y), .hit(overlap)
  );
`ifdef ENEMY_SHOT_LATCH_EN
  logic pend_q, pend_d;
  assign launch = (fire & bif.enemy_alive) | pend_q;
`else
  assign launch = fire & bif.enemy_alive;
`endif
  always_comb begin
    state_d = state_q;
    bullet_x_d = bullet_x_q;
    bullet_y_d = bullet_y_q;
    active_d = active_q;
    hit_d = 1'b0;
`ifdef ENEMY_SHOT_LATCH_EN
    pend_d = pend_q;
`endif
    case (state_q)
      IDLE: if (launch) begin
        state_d = LAUNCH;
        bullet_x_d = bif.enemy_x + COORD_W'(ENEMY_W / 2 - BULLET_W / 2);
        bullet_y_d = bif.enemy_y + COORD_W'(ENEMY_H);
`ifdef ENEMY_SHOT_LATCH_EN
        pend_d = 1'b0;
`endif
      end
      LAUNCH: begin
        state_d = FLY;
        active_d = 1'b1;
      end
      FLY: if (overlap) begin
        state_d = HIT;
        hit_d = 1'b1;
      end else if (bif.frame_tick) begin
        if (y_sum >= (COORD_W+1)'(SCREEN_H)) begin
          state_d = IDLE;
          active_d = 1'b0;
        end else bullet_y_d = y_sum[COORD_W-1:0];
      end
      default: begin
        state_d = IDLE;
        active_d = 1'b0;
      end
    endcase
`ifdef ENEMY_SHOT_LATCH_EN
    if (state_q != IDLE && fire && bif.enemy_alive) pend_d = 1'b1;
`endif
  end
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bullet_x_q <= '0;
      bullet_y_q <= '0;
      active_q <= 1'b0;
      hit_q <= 1'b0;
      busy_q <= 1'b0;
      shot_q <= 1'b0;
      req_q <= 1'b0;
`ifdef ENEMY_SHOT_LATCH_EN
      pend_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bullet_x_q <= bullet_x_d;
      bullet_y_q <= bullet_y_d;
      active_q <= active_d;
      hit_q <= hit_d;
      busy_q <= state_d != IDLE;
      shot_q <= bif.shot_req;
      req_q <= shot_q;
`ifdef ENEMY_SHOT_LATCH_EN
      pend_q <= pend_d;
`endif
    end
  end
  assign bif.bullet_x = bullet_x_q;
  assign bif.bullet_y = bullet_y_q;
  assign bif.bullet_active = active_q;
  assign bif.player_hit = hit_q;
  assign bif.busy = busy_q;
endmodule
